unwrap_data: RTL and testbench
==============================

Name: unwrap_data

Overview:
- Splits one combined row-major tensor stream into two streams.
- Per frame, the first WRAP_Y rows go to wrap_out; the remaining IN_Y rows go to data_out.
- It is the receive-side inverse of the prepend/wrap merger, used where a halo or padding region must be stripped from a stream and recycled separately.
- Each beat carries UNROLL_IN_X elements. Output is registered, with one-entry pipelining and full throughput.

Parameters:
IN_WIDTH, 32, element bit width
WRAP_Y, 1, leading rows per frame routed to wrap_out (must be >= 1)
IN_Y, 2, trailing rows per frame routed to data_out (must be >= 1)
IN_X, 10, elements per row (must be divisible by UNROLL_IN_X)
UNROLL_IN_X, 5, elements per beat

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
data_in  input  IN_WIDTH x [UNROLL_IN_X]  combined stream beat
data_in_valid  input  1  beat valid
data_in_ready  output  1  beat accepted when valid&&ready
wrap_out  output  IN_WIDTH x [UNROLL_IN_X]  wrap-region beat
wrap_out_valid  output  1  wrap beat valid
wrap_out_ready  input  1  wrap consumer ready
data_out  output  IN_WIDTH x [UNROLL_IN_X]  data-region beat
data_out_valid  output  1  data beat valid
data_out_ready  input  1  data consumer ready

Behaviour:
- Derived values:
  - ITER_X = IN_X/UNROLL_IN_X
  - ITER_Y = WRAP_Y+IN_Y
  - X_WIDTH = max(1,$clog2(ITER_X))
  - Y_WIDTH = max(1,$clog2(ITER_Y))
- Position counters in_x, in_y:
  - Advance only on input acceptance (data_in_valid && data_in_ready). Output handshakes never advance them.
  - x wraps at ITER_X-1 and increments y.
  - At (ITER_Y-1, ITER_X-1), both return to 0 (frame wrap).
- Routing state, enum {WRAP, DATA}:
  - WRAP while in_y < WRAP_Y; DATA otherwise.
  - On acceptance of the last beat of row WRAP_Y-1: WRAP -> DATA.
  - On acceptance of the last beat of the frame: DATA -> WRAP.
  - Mode is registered alongside the counters and is the tag captured with each beat.
- Output stage: one register slice holding {beat, tag, full}.
  - Pending destination ready: wrap_out_ready if tag==WRAP, else data_out_ready.
  - data_in_ready = !full || pending destination ready. Full throughput: drain and refill in the same cycle.
  - wrap_out_valid = full && tag==WRAP.
  - data_out_valid = full && tag==DATA.
  - wrap_out and data_out both present the held beat. The non-selected output's data is don't-care.
  - Latency: accepted beat appears on its output on the next clk edge, 1 cycle.
- Backpressure isolation:
  - The stalled destination blocks the input only while its beat is held.
  - The other output's ready has no effect.
  - No beat is reordered across the split: the frame sequence is strict.
- Valid/data stability: once valid is high on an output, the beat and valid hold until that output's ready is seen.
- Reset (asynchronous assert, synchronous-release usage):
  - in_x=0, in_y=0, mode=WRAP, full=0.
  - wrap_out_valid=0, data_out_valid=0.
  - Held beat cleared to 0.
  - data_in_ready forced 0 while rst high.
- Reset mid-frame discards the held beat and the frame position; the next accepted beat is frame beat 0 (WRAP).
- Simultaneous drain+accept: the held beat leaves, and the new beat (possibly the other tag) is loaded in the same edge.
- Counter widths: compare at full width without truncation warnings; comparisons against ITER_* use explicitly sized constants.

Decomposition:
- Shared package (common): typedef enum {WRAP, DATA} wrap_mode_t, shared with the merger.
- Sub-module register_slice:
  - Parameters DATA_WIDTH; single-entry valid/ready pipeline register with the same reset style.
  - Instantiated once with DATA_WIDTH = IN_WIDTH*UNROLL_IN_X+1 (flattened beat + tag).
  - Top-level demux of the slice output valid/ready by tag.

Test Plan:
(defaults: ITER_X=2, ITER_Y=3, 6 beats/frame)
- Streaming frame: 6 beats, values 1..6, both readies high. wrap_out receives 1,2; data_out receives 3,4,5,6. Each appears 1 cycle after acceptance; data_in_ready is high every cycle.
- Back-to-back frames: 12 beats continuous. Second frame beats 7,8 go to wrap_out and 9..12 to data_out. No bubble at the frame boundary.
- Backpressure on held beat: data_out_ready=0 while beat 3 is held. data_out_valid stays high with beat 3 stable and data_in_ready=0. wrap_out_ready toggling has no effect. Releasing ready drains beat 3 and accepts beat 4 in the same cycle.
- Idle gaps: data_in_valid toggles randomly with random readies, 100 frames. The scoreboard matches exact split order, with no loss or duplication.
- Reset mid-frame: assert rst after beat 4 is accepted, while beat 4 is held. Both valids drop to 0 immediately (asynchronous). After release, the next beat 9 goes to wrap_out as frame beat 0.
- Parameter sweep: WRAP_Y=2, IN_Y=1, IN_X=5, UNROLL_IN_X=5 (ITER_X=1). Beats 1,2 go to wrap_out and beat 3 to data_out, repeating.

Source files
------------

// File: rtl/unwrap_data_pkg.sv
// Shared types for the wrap/unwrap stream pair: routing mode tag and width helper.
package unwrap_data_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    DATA = 1'b1
  } wrap_mode_t;

  // Counter width for an iteration count; never narrower than one bit.
  function automatic int count_width(input int iterations);
    if (iterations <= 1) begin
      return 1;
    end else begin
      return $clog2(iterations);
    end
  endfunction

endpackage

// File: rtl/unwrap_data_register_slice.sv
// Single-entry valid/ready pipeline register; drains and refills in the same cycle.
module register_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic                  full;
  logic [DATA_WIDTH-1:0] held;

  // Never advertise space while reset is held, so no beat slips in during reset.
  assign in_ready  = !rst && (!full || out_ready);
  assign out_valid = full;
  assign out_data  = held;

  // Occupancy and payload of the single slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      held <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      held <= in_data;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/unwrap_data.sv
// Splits a row-major frame stream: the leading WRAP_Y rows go to wrap_out, the rest to data_out.
module unwrap_data
  import unwrap_data_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int WRAP_Y      = 1,
  parameter int IN_Y        = 2,
  parameter int IN_X        = 10,
  parameter int UNROLL_IN_X = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [UNROLL_IN_X-1:0][IN_WIDTH-1:0] data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [UNROLL_IN_X-1:0][IN_WIDTH-1:0] wrap_out,
  output logic                                 wrap_out_valid,
  input  logic                                 wrap_out_ready,
  output logic [UNROLL_IN_X-1:0][IN_WIDTH-1:0] data_out,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int ITER_X  = IN_X / UNROLL_IN_X;
  localparam int ITER_Y  = WRAP_Y + IN_Y;
  localparam int X_WIDTH = count_width(ITER_X);
  localparam int Y_WIDTH = count_width(ITER_Y);
  localparam int BEAT_W  = IN_WIDTH * UNROLL_IN_X;
  localparam int SLICE_W = BEAT_W + 1;

  localparam logic [X_WIDTH-1:0] X_LAST      = X_WIDTH'(ITER_X - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST      = Y_WIDTH'(ITER_Y - 1);
  localparam logic [Y_WIDTH-1:0] Y_WRAP_LAST = Y_WIDTH'(WRAP_Y - 1);

  logic [X_WIDTH-1:0] in_x;
  logic [Y_WIDTH-1:0] in_y;
  wrap_mode_t         mode;
  logic               accept;
  logic               row_end;

  logic [SLICE_W-1:0] slice_in;
  logic [SLICE_W-1:0] slice_out;
  logic               slice_valid;
  logic               slice_ready;
  wrap_mode_t         held_tag;
  logic [BEAT_W-1:0]  held_beat;

  assign accept  = data_in_valid && data_in_ready;
  assign row_end = (in_x == X_LAST);

  // Frame position and routing mode advance only when an input beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_x <= '0;
      in_y <= '0;
      mode <= WRAP;
    end else if (accept) begin
      if (row_end) begin
        in_x <= '0;
        if (in_y == Y_LAST) begin
          in_y <= '0;
          mode <= WRAP;
        end else begin
          in_y <= in_y + Y_WIDTH'(1);
          if (in_y == Y_WRAP_LAST) begin
            mode <= DATA;
          end
        end
      end else begin
        in_x <= in_x + X_WIDTH'(1);
      end
    end
  end

  // The routing tag rides in the top bit of the slice next to the flattened beat.
  assign slice_in = {mode, data_in};

  register_slice #(
    .DATA_WIDTH(SLICE_W)
  ) u_slice (
    .clk      (clk),
    .rst      (rst),
    .in_data  (slice_in),
    .in_valid (data_in_valid),
    .in_ready (data_in_ready),
    .out_data (slice_out),
    .out_valid(slice_valid),
    .out_ready(slice_ready)
  );

  assign held_tag  = wrap_mode_t'(slice_out[BEAT_W]);
  assign held_beat = slice_out[BEAT_W-1:0];

  // Only the destination owning the held beat can stall the slice.
  assign slice_ready    = (held_tag == WRAP) ? wrap_out_ready : data_out_ready;
  assign wrap_out_valid = slice_valid && (held_tag == WRAP);
  assign data_out_valid = slice_valid && (held_tag == DATA);
  assign wrap_out       = held_beat;
  assign data_out       = held_beat;

endmodule

// File: tb/tb_unwrap_data.sv
// Randomised and directed bench for unwrap_data: default geometry (dut 0) and a one-beat-per-row sweep (dut 1).
module tb_unwrap_data;

  localparam int W  = 32;
  localparam int U  = 5;
  localparam int BW = W * U;
  localparam int LOG_DEPTH = 2048;

  localparam int WY0 = 1, IY0 = 2, IX0 = 10;
  localparam int WY1 = 2, IY1 = 1, IX1 = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [U-1:0][W-1:0] din  [2];
  logic [U-1:0][W-1:0] wout [2];
  logic [U-1:0][W-1:0] dout [2];
  logic din_valid [2], din_ready [2];
  logic wout_valid[2], wout_ready[2];
  logic dout_valid[2], dout_ready[2];

  unwrap_data #(.IN_WIDTH(W), .WRAP_Y(WY0), .IN_Y(IY0), .IN_X(IX0), .UNROLL_IN_X(U)) dut0 (
    .clk(clk), .rst(rst),
    .data_in(din[0]), .data_in_valid(din_valid[0]), .data_in_ready(din_ready[0]),
    .wrap_out(wout[0]), .wrap_out_valid(wout_valid[0]), .wrap_out_ready(wout_ready[0]),
    .data_out(dout[0]), .data_out_valid(dout_valid[0]), .data_out_ready(dout_ready[0])
  );

  unwrap_data #(.IN_WIDTH(W), .WRAP_Y(WY1), .IN_Y(IY1), .IN_X(IX1), .UNROLL_IN_X(U)) dut1 (
    .clk(clk), .rst(rst),
    .data_in(din[1]), .data_in_valid(din_valid[1]), .data_in_ready(din_ready[1]),
    .wrap_out(wout[1]), .wrap_out_valid(wout_valid[1]), .wrap_out_ready(wout_ready[1]),
    .data_out(dout[1]), .data_out_valid(dout_valid[1]), .data_out_ready(dout_ready[1])
  );

  // Reference model: beats logged in acceptance order, destination from frame position.
  logic [BW-1:0] log_mem [2][0:LOG_DEPTH-1];
  int  n_acc[2], hk[2], nw[2], nd[2];
  bit  full_m[2], accepted[2];
  int  n_cmp = 0, n_bad = 0;

  function automatic int frame_len(input int d);
    return (d == 0) ? (WY0 + IY0) * (IX0 / U) : (WY1 + IY1) * (IX1 / U);
  endfunction

  function automatic int wrap_len(input int d);
    return (d == 0) ? WY0 * (IX0 / U) : WY1 * (IX1 / U);
  endfunction

  function automatic bit is_wrap(input int d, input int k);
    return (k % frame_len(d)) < wrap_len(d);
  endfunction

  function automatic logic [BW-1:0] mk(input int v);
    logic [BW-1:0] r;
    for (int e = 0; e < U; e++) r[e*W +: W] = W'(v * 16 + e);
    return r;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n_acc[d] = 0; hk[d] = 0; nw[d] = 0; nd[d] = 0;
      full_m[d] = 1'b0; accepted[d] = 1'b0;
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      din_valid[d] = 1'b0; wout_ready[d] = 1'b1; dout_ready[d] = 1'b1;
    end
  endtask

  // Called at a falling edge with inputs already set; checks, updates the model, advances one cycle.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      bit held_w, held_d, dest_rdy;
      held_w   = full_m[d] && is_wrap(d, hk[d]);
      held_d   = full_m[d] && !is_wrap(d, hk[d]);
      dest_rdy = held_w ? wout_ready[d] : dout_ready[d];
      check($sformatf("in_ready%0d", d), din_ready[d], !full_m[d] || dest_rdy);
      check($sformatf("wrap_valid%0d", d), wout_valid[d], held_w);
      check($sformatf("data_valid%0d", d), dout_valid[d], held_d);
      if (held_w) check($sformatf("wrap_beat%0d", d), wout[d], log_mem[d][hk[d] % LOG_DEPTH]);
      if (held_d) check($sformatf("data_beat%0d", d), dout[d], log_mem[d][hk[d] % LOG_DEPTH]);
      accepted[d] = din_valid[d] && din_ready[d];
      if (full_m[d] && dest_rdy) begin
        if (held_w) nw[d]++; else nd[d]++;
        full_m[d] = 1'b0;
      end
      if (accepted[d]) begin
        log_mem[d][n_acc[d] % LOG_DEPTH] = din[d];
        hk[d] = n_acc[d];
        n_acc[d]++;
        full_m[d] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Continuous valid on one dut; reports how many cycles the count took.
  task automatic stream(input int d, input int first, input int count, output int steps);
    int v;
    v = first; steps = 0;
    din_valid[d] = 1'b1;
    while (v < first + count && steps < 200) begin
      din[d] = mk(v);
      step();
      if (accepted[d]) v++;
      steps++;
    end
    din_valid[d] = 1'b0;
    check($sformatf("stream_done%0d", d), v, first + count);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int steps, v, stallc, it, ew, ed, nw0, nd0;
    bit done;
    rst = 1'b1;
    idle_all();
    for (int d = 0; d < 2; d++) din[d] = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_wvalid%0d", d), wout_valid[d], 1'b0);
      check($sformatf("rst_dvalid%0d", d), dout_valid[d], 1'b0);
      check($sformatf("rst_ready%0d", d), din_ready[d], 1'b0);
      check($sformatf("rst_beat%0d", d), wout[d], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();

    // Streaming frame, then a back-to-back second frame.
    stream(0, 1, 6, steps);
    check("stream_no_bubble", steps, 6);
    step();
    check("frame1_wrap_count", nw[0], 2);
    check("frame1_data_count", nd[0], 4);
    stream(0, 7, 6, steps);
    check("b2b_no_bubble", steps, 6);
    step();
    check("frame2_wrap_count", nw[0], 4);
    check("frame2_data_count", nd[0], 8);

    // Hold frame beat 2 on data_out for three cycles while wrap_out_ready toggles.
    v = 13; stallc = 0; it = 0;
    din_valid[0] = 1'b1;
    while (v < 19 && it < 100) begin
      din[0] = mk(v);
      dout_ready[0] = !(full_m[0] && (hk[0] % 6) == 2 && stallc < 3);
      if (!dout_ready[0]) stallc++;
      wout_ready[0] = ($urandom_range(0, 1) == 1) || !(full_m[0] && is_wrap(0, hk[0]));
      step();
      if (accepted[0]) v++;
      it++;
    end
    idle_all();
    step();
    check("stall_cycles", stallc, 3);
    check("bp_wrap_count", nw[0], 6);
    check("bp_data_count", nd[0], 12);

    // Random valid gaps and readies on both duts, 100 frames each.
    nw0 = n_acc[0]; nd0 = n_acc[1];
    done = 1'b0;
    for (it = 0; it < 8000 && !done; it++) begin
      for (int d = 0; d < 2; d++) begin
        if (!din_valid[d] || accepted[d]) begin
          din_valid[d] = ($urandom_range(0, 3) != 0);
          for (int e = 0; e < U; e++) din[d][e] = $urandom;
        end
        wout_ready[d] = ($urandom_range(0, 3) != 0);
        dout_ready[d] = ($urandom_range(0, 3) != 0);
      end
      step();
      done = (n_acc[0] >= nw0 + 600) && (n_acc[1] >= nd0 + 300);
    end
    check("random_budget", done, 1'b1);
    idle_all();
    step(); step();
    for (int d = 0; d < 2; d++) begin
      ew = 0; ed = 0;
      for (int k = 0; k < n_acc[d]; k++) if (is_wrap(d, k)) ew++; else ed++;
      check($sformatf("total_wrap%0d", d), nw[d], ew);
      check($sformatf("total_data%0d", d), nd[d], ed);
    end

    // Reset while frame beat 3 of dut 0 is held.
    v = 1; it = 0; done = 1'b0;
    din_valid[0] = 1'b1;
    while (!done && it < 50) begin
      din[0] = mk(v);
      step();
      if (accepted[0]) begin
        done = ((n_acc[0] - 1) % 6) == 3;
        v++;
      end
      it++;
    end
    check("reach_beat4", done, 1'b1);
    idle_all();
    dout_ready[0] = 1'b0;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_wvalid%0d", d), wout_valid[d], 1'b0);
      check($sformatf("midrst_dvalid%0d", d), dout_valid[d], 1'b0);
      check($sformatf("midrst_ready%0d", d), din_ready[d], 1'b0);
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    dout_ready[0] = 1'b1;
    stream(0, 9, 1, steps);
    check("post_rst_wvalid", wout_valid[0], 1'b1);
    check("post_rst_beat", wout[0], mk(9));
    step();
    check("post_rst_wrap_count", nw[0], 1);

    // Sweep geometry: two wrap beats then one data beat per frame.
    stream(1, 1, 6, steps);
    check("sweep_no_bubble", steps, 6);
    step();
    check("sweep_wrap_count", nw[1], 4);
    check("sweep_data_count", nd[1], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
